bcd_serial_adder: RTL and testbench
===================================

# bcd_serial_adder

Digit-serial BCD adder for the TP2 ALU datapath. It sits directly downstream of the 1-bit full-adder cell: it chains four full adders into a 4-bit binary digit adder, then applies the +6 decimal correction. Operands are processed one BCD digit per clock, least-significant digit first, under a Start/Done handshake. The block presents a packed BCD sum, decimal carry-out and an invalid-digit flag to the ALU result mux.

## Interface

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1).

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request to begin an addition; sampled only when Busy=0.
- A  in  4*DIGITS  packed BCD operand; digit i is A[4i+3:4i].
- B  in  4*DIGITS  packed BCD operand, same packing as A.
- Cin  in  1  decimal carry-in.
- Busy  out  1  high while digits are being processed.
- Done  out  1  one-cycle pulse when S, Cout and Invalid are final.
- S  out  4*DIGITS  packed BCD sum.
- Cout  out  1  decimal carry-out of the most-significant digit.
- Invalid  out  1  sticky flag: some operand digit was >9 in this operation.

## Operation

- States: IDLE, ADD, DONE. The state register, digit index (clog2(DIGITS) bits, minimum 1 bit), carry register and operand shift registers are internal.
- Reset: state=IDLE; S=0, Cout=0, Busy=0, Done=0, Invalid=0; internal carry=0 and index=0.
- IDLE or DONE with Start=1 (accepting edge):
  - A, B and Cin are latched into internal registers.
  - S←0, Cout←0, Invalid←0, index←0.
  - State→ADD.
- IDLE or DONE with Start=0: DONE→IDLE; IDLE holds. S, Cout and Invalid keep their values.
- ADD, each edge, digit i=index:
  - Binary sum t = a_i + b_i + c. This is a 5-bit value, range 0..31, formed by the 4-full-adder ripple chain.
  - If t>9: digit = (t+6)[3:0] and c←1. Otherwise: digit = t[3:0] and c←0.
  - S[4i+3:4i]←digit.
  - If a_i>9 or b_i>9, Invalid←1. Invalid never clears during the operation.
  - If i=DIGITS-1: Cout←c_next and state→DONE. Otherwise index←i+1.
- Start while in ADD is ignored. The latched operands are unaffected, and A/B/Cin changes during ADD have no effect.
- Invalid operands still produce the deterministic result defined by the rule above.
- Busy = (state==ADD). Done = (state==DONE).

## Timing

- Accepting edge E0. Digit i is written at edge E(i+1). The final digit and Cout are written at edge E(DIGITS).
- Done is high for exactly the cycle after E(DIGITS).
- Start-to-Done latency is DIGITS cycles. Busy is high for the DIGITS cycles after E0.
- Back-to-back operation: Start high during the Done cycle is accepted at edge E(DIGITS+1). Sustained throughput is one result per DIGITS+1 cycles.
- S is partially updated while Busy=1. It is valid only while Done=1 and afterwards, until the next accepting edge.
- Reset has priority over every other event, including mid-ADD and coincident with Start. At the reset edge the block returns to IDLE with all outputs 0. No Done is produced for the aborted operation.

## Test plan

All scenarios use DIGITS=4.
- Basic add: A=0x1234, B=0x5678, Cin=0, Start pulse → Done exactly 4 cycles after the accepting edge; S=0x6912, Cout=0, Invalid=0; Busy high for 4 cycles.
- Full carry ripple: A=0x9999, B=0x0001, Cin=0 → S=0x0000, Cout=1. Then A=0x9999, B=0x9999, Cin=1 → S=0x9999, Cout=1.
- Invalid digit: A=0x00A0, B=0x0000, Cin=0 → Invalid=1, S=0x0100, Cout=0. A following valid operation must clear Invalid.
- Start during ADD: second Start with A=0x1111, B=0x1111 two cycles into 0x1234+0x5678 → ignored; result 0x6912 with Done at the original time. Back-to-back: Start held high in the Done cycle → next result 0x2222 four cycles later.
- Reset mid-op: assert Reset at the edge after digit 1 is written → all outputs 0, no Done pulse. A new Start then yields the correct result.
- Randomized: 1000 valid-BCD operand pairs with random Cin, compared against a decimal reference model, with random Start spacing including back-to-back.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
//   Digit-serial BCD adder. A 4-bit ripple of full adders forms the binary
//   digit sum and a +6 correction returns it to BCD. One digit is processed
//   per clock, least-significant first, under a Start/Done handshake.
//
// Ports
//   Clk      clock, rising edge
//   Reset    synchronous active-high reset
//   Start    begin an addition (accepted in IDLE or DONE)
//   A, B     packed BCD operands, digit i at [4i+3:4i]
//   Cin      decimal carry-in
//   Busy     high while digits are being processed
//   Done     one-cycle pulse when S/Cout/Invalid are final
//   S        packed BCD sum
//   Cout     decimal carry-out of the most-significant digit
//   Invalid  sticky: some operand digit was >9 in this operation
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [4*DIGITS-1:0] A,
    input  logic [4*DIGITS-1:0] B,
    input  logic                Cin,
    output logic                Busy,
    output logic                Done,
    output logic [4*DIGITS-1:0] S,
    output logic                Cout,
    output logic                Invalid
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned W  = 4 * DIGITS;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;

    logic          accept;
    logic          last;
    logic [3:0]    a_d;
    logic [3:0]    b_d;
    logic          rip_c;
    logic [4:0]    t;
    logic [4:0]    t_adj;
    logic [3:0]    digit;
    logic          carry_nxt;
    logic          bad;

    // Operands shift right one digit per ADD cycle, so the current digit
    // is always in the low nibble.
    assign a_d  = a_sr[3:0];
    assign b_d  = b_sr[3:0];
    assign last = (idx == LAST);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                Busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = ADD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Four-full-adder ripple chain followed by the decimal correction
    always_comb begin
        t     = '0;
        rip_c = carry;
        for (int unsigned k = 0; k < 4; k++) begin
            t[k]  = a_d[k] ^ b_d[k] ^ rip_c;
            rip_c = (a_d[k] & b_d[k]) | (rip_c & (a_d[k] ^ b_d[k]));
        end
        t[4]  = rip_c;
        t_adj = t + 5'd6;
        if (t > 5'd9) begin
            digit     = t_adj[3:0];
            carry_nxt = 1'b1;
        end else begin
            digit     = t[3:0];
            carry_nxt = 1'b0;
        end
        bad = (a_d > 4'd9) || (b_d > 4'd9);
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            S       <= '0;
            Cout    <= 1'b0;
            Invalid <= 1'b0;
            carry   <= 1'b0;
            idx     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
        end else if (accept) begin
            a_sr    <= A;
            b_sr    <= B;
            carry   <= Cin;
            S       <= '0;
            Cout    <= 1'b0;
            Invalid <= 1'b0;
            idx     <= '0;
        end else if (state == ADD) begin
            S[4*idx +: 4] <= digit;
            carry         <= carry_nxt;
            a_sr          <= a_sr >> 4;
            b_sr          <= b_sr >> 4;
            if (bad) begin
                Invalid <= 1'b1;
            end
            if (last) begin
                Cout <= carry_nxt;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder
//   Scoreboard bench for bcd_serial_adder (DIGITS=4). Expected results are
//   queued at the accepting edge and compared in the Done cycle. Busy and
//   Done are compared every cycle against a cycle-count model.
module tb_bcd_serial_adder;

    localparam int D = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [15:0]   A = '0;
    logic [15:0]   B = '0;
    logic          Cin = 1'b0;
    logic          Busy;
    logic          Done;
    logic [15:0]   S;
    logic          Cout;
    logic          Invalid;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Cin     (Cin),
        .Busy    (Busy),
        .Done    (Done),
        .S       (S),
        .Cout    (Cout),
        .Invalid (Invalid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        inv;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc = -100;
    logic [15:0] pend_s = '0;
    logic        pend_c = 1'b0;
    logic        pend_i = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] v = '0;
        int m = n;
        for (int i = 0; i < 4; i++) begin
            v[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return v;
    endfunction

    // One clock: model update at the rising edge, checks at the falling edge.
    task automatic tick();
        int   prev;
        logic was_busy;
        logic exp_busy;
        logic exp_done;
        exp_t e;
        @(posedge Clk);
        prev = cyc;
        cyc++;
        was_busy = (last_acc >= 0) && (prev >= last_acc) && (prev <= last_acc + D - 1);
        if (Reset) begin
            q.delete();
            last_acc = -100;
        end else if (Start && !was_busy) begin
            last_acc = cyc;
            q.push_back('{pend_s, pend_c, pend_i});
        end
        @(negedge Clk);
        exp_busy = (last_acc >= 0) && (cyc >= last_acc) && (cyc <= last_acc + D - 1);
        exp_done = (last_acc >= 0) && (cyc == last_acc + D);
        check("busy", Busy, exp_busy);
        check("done", Done, exp_done);
        if (exp_done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got no queued result, expected one (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("sum", S, e.s);
                check("cout", Cout, e.c);
                check("invalid", Invalid, e.inv);
            end
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] es, input logic ec, input logic ei);
        A = a;
        B = b;
        Cin = cin;
        pend_s = es;
        pend_c = ec;
        pend_i = ei;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic run_rand(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int sum;
        sum = bcd2int(a) + bcd2int(b) + int'(cin);
        run_op(a, b, cin, int2bcd(sum % 10000), (sum >= 10000), 1'b0);
    endtask

    task automatic wait_done_cycle();
        int guard = 0;
        while (!(last_acc >= 0 && cyc >= last_acc + D)) begin
            if (guard > 50) begin
                checks++;
                errors++;
                $display("FAIL wait_done: got no done cycle within 50 cycles, expected one");
                return;
            end
            guard++;
            tick();
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          gap;

        // Reset state
        Reset = 1'b1;
        tick();
        tick();
        check("reset_s", S, 16'h0000);
        check("reset_cout", Cout, 1'b0);
        check("reset_invalid", Invalid, 1'b0);
        Reset = 1'b0;
        tick();

        // Basic add
        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        wait_done_cycle();
        tick();

        // Full carry ripple
        run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        wait_done_cycle();
        run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        wait_done_cycle();
        tick();

        // Invalid digit, then a valid op must clear the flag
        run_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
        wait_done_cycle();
        tick();
        tick();
        check("invalid_hold", Invalid, 1'b1);
        run_op(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);
        wait_done_cycle();
        tick();

        // Start during ADD is ignored; back-to-back Start in the Done cycle
        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        tick();
        A = 16'h1111;
        B = 16'h1111;
        Cin = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done_cycle();
        run_op(16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0);
        wait_done_cycle();
        tick();

        // Reset mid-operation, after digit 1 has been written
        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_s", S, 16'h0000);
        check("abort_cout", Cout, 1'b0);
        check("abort_invalid", Invalid, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        run_op(16'h4321, 16'h0789, 1'b1, 16'h5111, 1'b0, 1'b0);
        wait_done_cycle();

        // Randomized valid BCD with random spacing
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 4; k++) begin
                ra[4*k +: 4] = 4'($urandom_range(0, 9));
                rb[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            gap = int'($urandom_range(0, 3));
            while (last_acc >= 0 && cyc < last_acc + D + gap) tick();
            run_rand(ra, rb, 1'($urandom_range(0, 1)));
        end
        wait_done_cycle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
